// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types and helpers for the sequential shift-add multiplier
package mult_seq_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the RUN-cycle counter: enough to count 0..m-1, never narrower than one bit
  function automatic int cnt_width(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/RCA.sv
// rtl/RCA.sv - parameterised ripple-carry adder
module RCA #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  output logic [W-1:0] S,
  output logic         Co
);

  logic [W:0] w_c;

  assign w_c[0] = Ci;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign S[i]     = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Co = w_c[W];

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequential shift-add unsigned multiplier (optional macro MULT_SEQ_EARLY_EXIT_EN)
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] p
);

  localparam int W  = N + M;
  localparam int CW = cnt_width(M);
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_a_sh;
  logic [M-1:0]  r_b_sh;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_sum;
  logic [M-1:0]  w_b_nxt;
  logic          w_accept;
  logic          w_last;
  logic          w_unused_co;

  // The product fits in W bits, so the adder carry-out is always zero
  RCA #(.W(W)) u_rca (
    .A  (r_acc),
    .B  (r_a_sh),
    .Ci (1'b0),
    .S  (w_sum),
    .Co (w_unused_co)
  );

  assign w_b_nxt  = r_b_sh >> 1;
  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign p        = r_acc;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Stop as soon as no multiplier bits remain after this cycle
  assign w_last = (r_cnt == CNT_LAST) || (w_b_nxt == '0);
`else
  // Fixed, data-independent latency of M RUN cycles
  assign w_last = (r_cnt == CNT_LAST);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand load at accept, then one shift-add step per RUN cycle; held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_acc  <= '0;
      r_a_sh <= W'(a);
      r_b_sh <= b;
      r_cnt  <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_b_sh[0]) r_acc <= w_sum;
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= w_b_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - scoreboard bench for mult_seq_ctrl (4x4 and 8x3 instances)
module tb_mult_seq_ctrl;

  localparam int N0 = 4;
  localparam int M0 = 4;
  localparam int N1 = 8;
  localparam int M1 = 3;

  typedef struct {
    logic [10:0] p;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  iv = '0;
  logic [1:0]  ordy = '0;
  wire  [1:0]  ir;
  wire  [1:0]  ov;
  logic [3:0]  a0 = '0;
  logic [3:0]  b0 = '0;
  logic [7:0]  a1 = '0;
  logic [2:0]  b1 = '0;
  logic [7:0]  p0;
  logic [10:0] p1;
  logic [10:0] pv [2];

  exp_t q0[$];
  exp_t q1[$];

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc [2];
  logic        prev_ov [2];
  logic [10:0] held [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign pv[0] = {3'b000, p0};
  assign pv[1] = p1;

  mult_seq_ctrl #(.N(N0), .M(M0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .a         (a0),
    .b         (b0),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .p         (p0)
  );

  mult_seq_ctrl #(.N(N1), .M(M1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .a         (a1),
    .b         (b1),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .p         (p1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] b, input int m);
    int l;
    l = m;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < m; i++) if (b[i]) l = i + 1;
`endif
    return l;
  endfunction

  // Monitor: runs on the falling edge, away from the DUT's active edge
  task automatic mon(input int d);
    exp_t e;
    if (!rst_n) begin
      prev_ov[d] = 1'b0;
      return;
    end
    if (iv[d] && ir[d]) acc_cyc[d] = cyc + 1;
    chk($sformatf("hs_excl_dut%0d", d), {31'd0, ir[d] & ov[d]}, 32'd0);
    if (ov[d] && !prev_ov[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected_out_dut%0d", d), 32'd1, 32'd0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("product_dut%0d", d), {21'd0, pv[d]}, {21'd0, e.p});
        chk($sformatf("latency_dut%0d", d), cyc - acc_cyc[d], e.lat);
        held[d] = e.p;
      end
    end else if (ov[d]) begin
      chk($sformatf("p_stable_dut%0d", d), {21'd0, pv[d]}, {21'd0, held[d]});
    end
    prev_ov[d] = ov[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int d, input logic [7:0] a, input logic [3:0] b, input logic [10:0] expp);
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      if (ir[d]) break;
      @(posedge clk); #1;
    end
    if (!ir[d]) begin
      chk($sformatf("timeout_in_ready_dut%0d", d), 32'd0, 32'd1);
      return;
    end
    e.p   = expp;
    e.lat = exp_lat(b, (d == 0) ? M0 : M1);
    if (d == 0) begin
      q0.push_back(e);
      a0 = a[3:0];
      b0 = b;
    end else begin
      q1.push_back(e);
      a1 = a;
      b1 = b[2:0];
    end
    iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int hold, input logic [10:0] expp);
    for (int i = 0; i < 100; i++) begin
      if (ov[d]) break;
      @(posedge clk); #1;
    end
    if (!ov[d]) begin
      chk($sformatf("timeout_out_valid_dut%0d", d), 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_out_valid_dut%0d", d), {31'd0, ov[d]}, 32'd1);
      chk($sformatf("stall_in_ready_dut%0d", d), {31'd0, ir[d]}, 32'd0);
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk($sformatf("idle_in_ready_dut%0d", d), {31'd0, ir[d]}, 32'd1);
    chk($sformatf("idle_p_hold_dut%0d", d), {21'd0, pv[d]}, {21'd0, expp});
  endtask

  initial begin
    logic [7:0] ra;
    logic [3:0] rb;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p", {21'd0, pv[0]}, 32'd0);
    chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
    chk("rst_in_ready_dut1", {31'd0, ir[1]}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed products on the 4x4 instance
    issue(0, 8'd13, 4'd11, 11'd143); wait_done(0, 0, 11'd143);
    issue(0, 8'd15, 4'd15, 11'd225); wait_done(0, 0, 11'd225);
    issue(0, 8'd9,  4'd0,  11'd0);   wait_done(0, 0, 11'd0);
    issue(0, 8'd7,  4'd2,  11'd14);  wait_done(0, 0, 11'd14);
    issue(0, 8'd1,  4'd1,  11'd1);   wait_done(0, 0, 11'd1);
    issue(0, 8'd15, 4'd8,  11'd120); wait_done(0, 0, 11'd120);

    // Backpressure: five stalled DONE cycles
    issue(0, 8'd6, 4'd5, 11'd30); wait_done(0, 5, 11'd30);

    // New operands pulsed during RUN must be ignored
    issue(0, 8'd10, 4'd13, 11'd130);
    a0 = 4'd15; b0 = 4'd15; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_done(0, 0, 11'd130);

    // Reset in the second RUN cycle discards the operation
    issue(0, 8'd12, 4'd9, 11'd108);
    @(posedge clk); #1;
    rst_n = 1'b0;
    void'(q0.pop_back());
    #1;
    chk("midrun_rst_p", {21'd0, pv[0]}, 32'd0);
    chk("midrun_rst_out_valid", {31'd0, ov[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_p", {21'd0, pv[0]}, 32'd0);
    chk("post_rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("post_rst_in_ready", {31'd0, ir[0]}, 32'd1);
    issue(0, 8'd3, 4'd5, 11'd15); wait_done(0, 0, 11'd15);

    // Asymmetric widths on the 8x3 instance
    issue(1, 8'd255, 4'd7, 11'd1785); wait_done(1, 0, 11'd1785);
    issue(1, 8'd200, 4'd4, 11'd800);  wait_done(1, 0, 11'd800);

    // Back-to-back random operations against the a*b reference
    ordy[1] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(0, 7));
      issue(1, ra, rb, 11'(ra * rb));
    end
    for (int i = 0; i < 100; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk); #1;
    end
    ordy[1] = 1'b0;
    chk("scoreboard_drain", q0.size() + q1.size(), 32'd0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
